// File: rtl/act_unpack8b.sv
// act_unpack8b: unpacks 4x8-bit activations per word into left-shifted 32-bit values, byte0 first.
// Latency: byte0 appears the cycle after the word is accepted, then 1 byte/cycle with no inter-word bubble.
// Backpressure: out_valid holds until taken; in_ready only while idle or as the last byte leaves. UNPACK_SAT_EN adds saturation.
module act_unpack8b #(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       AccReg_shift,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  input  logic [1:0]       in_bcnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] buf_q, buf_d;
  logic [4:0]  shift_q, shift_d;
  logic [2:0]  n_q, n_d;
  logic        last_q, last_d;
  logic [1:0]  idx_q, idx_d;

  logic        at_end;
  logic        accept;
  logic [7:0]  cur_byte;
  logic [OUT_W-1:0] res;
`ifdef UNPACK_SAT_EN
  logic [39:0] wide;
`endif

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    shift_d  = shift_q;
    n_d      = n_q;
    last_d   = last_q;
    idx_d    = idx_q;
    at_end   = ({1'b0, idx_q} == (n_q - 3'd1));
    // in_ready looks only at out_ready and registered state, never at in_valid
    in_ready = (state_q == IDLE) || (out_ready && at_end);
    accept   = in_valid && in_ready;

    if (accept) begin
      state_d = EMIT;
      buf_d   = in_data;
      shift_d = AccReg_shift;
      n_d     = (!in_last || in_bcnt == 2'd0) ? 3'd4 : {1'b0, in_bcnt};
      last_d  = in_last;
      idx_d   = 2'd0;
    end else if (state_q == EMIT && out_ready) begin
      if (at_end) state_d = IDLE;
      else        idx_d   = idx_q + 2'd1;
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    cur_byte = buf_q[7:0];
      2'd1:    cur_byte = buf_q[15:8];
      2'd2:    cur_byte = buf_q[23:16];
      default: cur_byte = buf_q[31:24];
    endcase
`ifdef UNPACK_SAT_EN
    wide = {32'd0, cur_byte} << shift_q;
    res  = (|wide[39:31]) ? 32'h7FFF_FFFF : wide[31:0];
`else
    res  = {24'd0, cur_byte} << shift_q;
`endif
    out_valid = (state_q == EMIT);
    out_data  = out_valid ? res : '0;
    out_last  = out_valid && last_q && at_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      shift_q <= '0;
      n_q     <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      shift_q <= shift_d;
      n_q     <= n_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: doc/act_unpack8b.md
Name: act_unpack8b

Overview:
- Reader-side counterpart of the 8-bit ReLU output path.
- Takes packed 32-bit words, each holding four unsigned 8-bit activations, through a valid/ready stream.
- Emits one 32-bit accumulator-domain value per byte: the byte re-scaled by a left shift of AccReg_shift.
- Sits between activation memory and the accumulator array. It preloads residual/bias data so it lines up with the scale used by the down-converting stage.

Parameters:
- OUT_W, 32, width of the re-scaled output value; fixed at 32, kept only for readability.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- AccReg_shift  input  5  left-shift amount; sampled with each accepted input word.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept an input word this cycle.
- in_data  input  32  packed bytes; byte0 = [7:0] is emitted first, byte3 = [31:24] last.
- in_last  input  1  word is the final word of a tile.
- in_bcnt  input  2  number of valid bytes in a last word; 0 means 4. Ignored when in_last=0.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  32  re-scaled value.
- out_last  output  1  out_data is the final byte of the tile.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, out_valid=0, out_last=0, out_data=0, in_ready=1. Internal word buffer, byte index and latched shift are cleared.
- Reset asserted mid-tile drops all buffered bytes. No output is produced after release until a new word is accepted.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, latch the following, then go to EMIT:
    - in_data
    - AccReg_shift
    - byte count n: 4 if in_last=0; otherwise in_bcnt, with 0 meaning 4
    - in_last
  - Set index idx=0.
- State EMIT:
  - out_valid=1; out_data = f(buffer byte[idx], latched shift).
  - out_last = latched_last && (idx==n-1).
  - On out_valid&&out_ready with idx<n-1: idx increments.
  - On out_valid&&out_ready with idx==n-1: the word is done.
  - in_ready = out_ready && (idx==n-1), so a new word can be accepted in the same cycle the final byte is taken.
  - Word done and in_valid=1: the new word loads, state stays EMIT, idx=0. Sustained throughput is 1 byte/cycle with no bubble.
  - Word done and in_valid=0: return to IDLE.
- Latency: a word accepted at edge N presents byte0 on out_data after edge N, in cycle N+1. Output is driven from registered state only; no combinational path from in_data to out_data.
- Stall: while out_valid=1 and out_ready=0, out_data, out_last and idx hold stable.
- AccReg_shift changes after a word is accepted do not affect that word's bytes.
- Arithmetic:
  - Zero-extend the byte, then left-shift by 0..31 in a 40-bit intermediate.
  - Result is always non-negative (bit 31 = 0 by saturation; see Optional Feature).
  - Byte 0 gives 0 for any shift.
- Handshake rules:
  - in_ready must not depend combinationally on in_valid.
  - out_valid must not depend combinationally on out_ready.
  - out_valid, once asserted, stays high until accepted.

Optional Feature:
- Macro UNPACK_SAT_EN.
- Defined: if any of intermediate bits [39:31] is nonzero, out_data = 32'h7FFFFFFF. Otherwise out_data = intermediate[31:0]. Output is always positive, matching the non-negative range the ReLU stage expects.
- Undefined: out_data = intermediate[31:0] (plain truncation, bit 31 may be set); no saturation logic is built.

Test Plan:
- Reset/idle: hold rst_n=0, then release with in_valid=0 -> out_valid=0, in_ready=1, out_data=0. Pulse rst_n=0 for 1 ns mid-EMIT -> out_valid drops immediately, no residual bytes appear after release.
- Basic unpack: shift=0, in_data=32'h04030201, in_last=1, in_bcnt=0, out_ready=1 -> outputs 1,2,3,4 on consecutive cycles starting the cycle after acceptance; out_last=1 only with value 4; in_ready=1 on the 4th output cycle.
- Shift and back-to-back: shift=4, two words 32'hFF80_0110 then 32'h0000_0001 (in_last=1, in_bcnt=1) with in_valid held high -> outputs 0x100, 0x10, 0x800, 0xFF0, 0x10 with no bubble; out_last only on the final 0x10.
- Backpressure: toggle out_ready 1,0,0,1 pattern during a word -> out_data/out_last stable while stalled; each byte emitted exactly once, in order; AccReg_shift changed to 9 mid-word has no effect.
- Saturation (UNPACK_SAT_EN defined): shift=31, byte 0x01 -> 0x7FFFFFFF; shift=24, byte 0x7F -> 0x7F000000; shift=24, byte 0x80 -> 0x7FFFFFFF. Without macro, the same three cases -> 0x80000000, 0x7F000000, 0x80000000.
- Partial last word: in_last=1, in_bcnt=2, in_data=32'hAABB_0605, shift=1 -> exactly two outputs, 0x0A then 0x0C with out_last=1; block returns to IDLE with in_ready=1.
